frame_capture_ctrl: RTL and testbench
=====================================

# frame_capture_ctrl

Frame-level capture sequencer for the sensor video path. It detects frame-valid and line-valid edges internally. Software arms it to capture a requested number of whole frames, and it gates pixel data downstream so that only complete frames, aligned to a frame start, pass. It also checks each captured frame's geometry against IMAGE_WIDTH × IMAGE_HEIGHT and flags mismatches.

## Interface
- IMAGE_WIDTH, 640: expected pixels per line (count of i_Lv-high cycles).
- IMAGE_HEIGHT, 512: expected lines per frame.
- DATA_W, 16: pixel width.
- FRAME_CNT_W, 8: width of the frame request and frame counters.
- i_Sys_clk  in  1  system clock; single clock domain.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Start  in  1  single-cycle arm pulse.
- i_Stop  in  1  single-cycle stop pulse.
- i_Frame_num  in  FRAME_CNT_W  frames to capture, latched on accepted i_Start; 0 = continuous.
- i_Fv  in  1  frame valid.
- i_Lv  in  1  line valid; only meaningful while i_Fv=1.
- i_Data  in  DATA_W  pixel data, qualified by i_Lv.
- o_Data  out  DATA_W  i_Data registered once.
- o_Cap_en  out  1  pixel-valid for o_Data.
- o_Sof  out  1  start-of-captured-frame pulse.
- o_Eol  out  1  end-of-captured-line pulse.
- o_Eof  out  1  end-of-captured-frame pulse.
- o_Done  out  1  capture-sequence-complete pulse.
- o_Busy  out  1  high whenever state ≠ IDLE.
- o_Err_size  out  1  sticky geometry error; cleared on accepted i_Start.
- o_Frame_cnt  out  FRAME_CNT_W  frames completed since last accepted i_Start.

## Operation
- Edge detection: fv_d1 and lv_d1 registers.
  - fv_rise = i_Fv & ~fv_d1; fv_fall = fv_d1 & ~i_Fv.
  - lv_fall = lv_d1 & ~i_Lv, and counts only while fv_d1=1.
- States: IDLE, ARMED, CAPTURE.
- IDLE:
  - On i_Start without i_Stop: go to ARMED, latch i_Frame_num, clear o_Frame_cnt and o_Err_size.
  - i_Start and i_Stop in the same cycle: stop wins, nothing happens.
- ARMED: waits for fv_rise.
  - If i_Fv is already high when arming, wait for the next rising edge; no partial frames.
  - fv_rise → CAPTURE.
  - i_Stop → IDLE immediately; no o_Done.
- CAPTURE: counts and gates pixels.
  - On fv_fall: o_Frame_cnt increments.
  - If stop_pending is set, or i_Frame_num≠0 and the new count equals i_Frame_num: go to IDLE and pulse o_Done.
  - Otherwise go to ARMED.
  - i_Stop in CAPTURE sets stop_pending, so the current frame finishes.
  - stop_pending clears on entry to IDLE.
- i_Start while o_Busy=1 is ignored.
- Continuous mode: o_Frame_cnt wraps modulo 2^FRAME_CNT_W.
- Pixel counter:
  - Clears on fv_rise and on each lv_fall.
  - Increments on each cycle with i_Lv & i_Fv during capture.
  - Saturates at all-ones, width $clog2(IMAGE_WIDTH+1)+1.
- Line counter:
  - Clears on fv_rise; increments on lv_fall during capture.
  - Saturates, width $clog2(IMAGE_HEIGHT+1)+1.
- o_Err_size sets when any of these occur in a captured frame:
  - on lv_fall, pixel count ≠ IMAGE_WIDTH;
  - on fv_fall, line count ≠ IMAGE_HEIGHT;
  - fv_fall while i_Lv is still high (truncated line; that line is not counted).
- Lines with i_Lv high while i_Fv is low are ignored: not counted, not gated out.

## Timing
- Reset values:
  - state = IDLE;
  - o_Data, o_Cap_en, o_Sof, o_Eol, o_Eof, o_Done, o_Busy, o_Err_size, o_Frame_cnt all 0;
  - all counters, fv_d1, lv_d1 and stop_pending all 0.
- All outputs are registered; one-cycle latency from input.
- Capture-active cycle: state=CAPTURE, or state=ARMED with fv_rise.
  - o_Cap_en(t+1) = i_Lv(t) & i_Fv(t) & capture-active(t).
  - o_Data(t+1) = i_Data(t), unconditionally.
- o_Sof: 1 cycle, at t+1 after the fv_rise accepted in ARMED.
- o_Eol: 1 cycle, at t+1 after lv_fall in CAPTURE.
- o_Eof: 1 cycle, at t+1 after fv_fall in CAPTURE.
  - o_Frame_cnt updates in the same cycle as o_Eof.
  - o_Done, when generated, coincides with o_Eof.
- o_Busy rises the cycle after the accepted i_Start and falls the cycle after the transition to IDLE (same cycle as o_Done).
- o_Err_size updates one cycle after the offending edge.
- Asynchronous reset mid-frame: everything returns to reset values immediately. After release, the block is in IDLE and a new i_Start waits for the next fv_rise.

## Test plan
- Single frame: i_Frame_num=1, i_Start, then one 640×512 frame.
  - Required: one o_Sof, 512 o_Eol, 640×512 o_Cap_en cycles, one o_Eof together with o_Done.
  - Required: o_Frame_cnt=1, o_Err_size=0, o_Busy low after o_Done.
- Arm mid-frame: i_Start while i_Fv=1.
  - Required: no o_Cap_en for the current frame; capture begins at the next rising edge of i_Fv.
- Geometry error: frame with one line of 639 pixels, then a frame with 511 lines.
  - Required: o_Err_size=1 one cycle after the short line's lv_fall; it stays set through o_Eof.
  - Required: the next i_Start clears it.
- Stop handling:
  - i_Frame_num=0, i_Stop in mid-frame 3 → frame 3 completes, then o_Done; o_Frame_cnt=3.
  - i_Stop while ARMED → IDLE next cycle, no o_Done.
- Simultaneous and ignored commands:
  - i_Start with i_Stop in IDLE → remains IDLE.
  - i_Start while busy → ignored; the latched i_Frame_num is unchanged.
- Async reset: assert i_Rst_n=0 mid-line.
  - Required: all outputs 0 immediately.
  - Required: after release, no capture until a new i_Start.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms on a software request, passes only whole frames aligned
// to a frame start, counts completed frames and flags frames whose geometry is wrong.
module frame_capture_ctrl #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 512,
    parameter int DATA_W       = 16,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic                   i_Sys_clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Start,
    input  logic                   i_Stop,
    input  logic [FRAME_CNT_W-1:0] i_Frame_num,
    input  logic                   i_Fv,
    input  logic                   i_Lv,
    input  logic [DATA_W-1:0]      i_Data,
    output logic [DATA_W-1:0]      o_Data,
    output logic                   o_Cap_en,
    output logic                   o_Sof,
    output logic                   o_Eol,
    output logic                   o_Eof,
    output logic                   o_Done,
    output logic                   o_Busy,
    output logic                   o_Err_size,
    output logic [FRAME_CNT_W-1:0] o_Frame_cnt
);
    localparam int PIX_W  = $clog2(IMAGE_WIDTH + 1) + 1;
    localparam int LINE_W = $clog2(IMAGE_HEIGHT + 1) + 1;
    localparam logic [PIX_W-1:0]  PIX_TARGET  = PIX_W'(IMAGE_WIDTH);
    localparam logic [LINE_W-1:0] LINE_TARGET = LINE_W'(IMAGE_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE
    } state_e;

    state_e                 state_q, state_d;
    logic                   fv_d1_q, fv_d1_d;
    logic                   lv_d1_q, lv_d1_d;
    logic [FRAME_CNT_W-1:0] frame_num_q, frame_num_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_inc;
    logic                   stop_pending_q, stop_pending_d;
    logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0]      line_cnt_q, line_cnt_d;
    logic [LINE_W-1:0]      line_cnt_next;
    logic                   err_q, err_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   cap_en_q, cap_en_d;
    logic                   sof_q, sof_d;
    logic                   eol_q, eol_d;
    logic                   eof_q, eof_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   fv_rise, fv_fall, lv_fall;
    logic                   cap_active;

    assign fv_rise = i_Fv & ~fv_d1_q;
    assign fv_fall = fv_d1_q & ~i_Fv;
    // A line end only counts while the frame was valid, so stray lines in blanking are ignored
    assign lv_fall = lv_d1_q & ~i_Lv & fv_d1_q;

    always_comb begin
        state_d        = state_q;
        fv_d1_d        = i_Fv;
        lv_d1_d        = i_Lv;
        frame_num_d    = frame_num_q;
        frame_cnt_d    = frame_cnt_q;
        frame_cnt_inc  = frame_cnt_q + FRAME_CNT_W'(1);
        stop_pending_d = stop_pending_q;
        err_d          = err_q;
        pix_cnt_d      = pix_cnt_q;
        line_cnt_d     = line_cnt_q;
        line_cnt_next  = line_cnt_q;
        data_d         = i_Data;
        sof_d          = 1'b0;
        eol_d          = 1'b0;
        eof_d          = 1'b0;
        done_d         = 1'b0;
        cap_active     = 1'b0;

        if (state_q == ST_CAPTURE && lv_fall && line_cnt_q != '1) begin
            line_cnt_next = line_cnt_q + LINE_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_Start && !i_Stop) begin
                    state_d     = ST_ARMED;
                    frame_num_d = i_Frame_num;
                    frame_cnt_d = '0;
                    err_d       = 1'b0;
                end
            end
            ST_ARMED: begin
                if (i_Stop) begin
                    state_d = ST_IDLE;
                end else if (fv_rise) begin
                    state_d    = ST_CAPTURE;
                    sof_d      = 1'b1;
                    cap_active = 1'b1;
                end
            end
            ST_CAPTURE: begin
                cap_active = 1'b1;
                if (i_Stop) begin
                    stop_pending_d = 1'b1;
                end
                if (lv_fall) begin
                    eol_d = 1'b1;
                    if (pix_cnt_q != PIX_TARGET) begin
                        err_d = 1'b1;
                    end
                end
                // Line count includes a line ending on this same cycle; a line cut by fv_fall is not counted
                if (fv_fall) begin
                    eof_d       = 1'b1;
                    frame_cnt_d = frame_cnt_inc;
                    if (line_cnt_next != LINE_TARGET || i_Lv) begin
                        err_d = 1'b1;
                    end
                    if (stop_pending_q || i_Stop ||
                        (frame_num_q != '0 && frame_cnt_inc == frame_num_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            stop_pending_d = 1'b0;
        end

        if (fv_rise) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
        end else begin
            line_cnt_d = line_cnt_next;
        end
        if (lv_fall) begin
            pix_cnt_d = '0;
        end
        if (cap_active && i_Lv && i_Fv && pix_cnt_d != '1) begin
            pix_cnt_d = pix_cnt_d + PIX_W'(1);
        end

        cap_en_d = cap_active & i_Lv & i_Fv;
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q        <= ST_IDLE;
            fv_d1_q        <= 1'b0;
            lv_d1_q        <= 1'b0;
            frame_num_q    <= '0;
            frame_cnt_q    <= '0;
            stop_pending_q <= 1'b0;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            err_q          <= 1'b0;
            data_q         <= '0;
            cap_en_q       <= 1'b0;
            sof_q          <= 1'b0;
            eol_q          <= 1'b0;
            eof_q          <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            fv_d1_q        <= fv_d1_d;
            lv_d1_q        <= lv_d1_d;
            frame_num_q    <= frame_num_d;
            frame_cnt_q    <= frame_cnt_d;
            stop_pending_q <= stop_pending_d;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            err_q          <= err_d;
            data_q         <= data_d;
            cap_en_q       <= cap_en_d;
            sof_q          <= sof_d;
            eol_q          <= eol_d;
            eof_q          <= eof_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    assign o_Data      = data_q;
    assign o_Cap_en    = cap_en_q;
    assign o_Sof       = sof_q;
    assign o_Eol       = eol_q;
    assign o_Eof       = eof_q;
    assign o_Done      = done_q;
    assign o_Busy      = busy_q;
    assign o_Err_size  = err_q;
    assign o_Frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomized frame-level bench for frame_capture_ctrl, using a small image geometry and a
// frame-granular reference model of the capture sequencer.
module tb_frame_capture_ctrl;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 16;
    localparam int FW = 8;

    logic          i_Sys_clk = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic          i_Start = 1'b0;
    logic          i_Stop = 1'b0;
    logic [FW-1:0] i_Frame_num = '0;
    logic          i_Fv = 1'b0;
    logic          i_Lv = 1'b0;
    logic [DW-1:0] i_Data = '0;
    logic [DW-1:0] o_Data;
    logic          o_Cap_en, o_Sof, o_Eol, o_Eof, o_Done, o_Busy, o_Err_size;
    logic [FW-1:0] o_Frame_cnt;

    frame_capture_ctrl #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .DATA_W      (DW),
        .FRAME_CNT_W (FW)
    ) dut (
        .i_Sys_clk  (i_Sys_clk),
        .i_Rst_n    (i_Rst_n),
        .i_Start    (i_Start),
        .i_Stop     (i_Stop),
        .i_Frame_num(i_Frame_num),
        .i_Fv       (i_Fv),
        .i_Lv       (i_Lv),
        .i_Data     (i_Data),
        .o_Data     (o_Data),
        .o_Cap_en   (o_Cap_en),
        .o_Sof      (o_Sof),
        .o_Eol      (o_Eol),
        .o_Eof      (o_Eof),
        .o_Done     (o_Done),
        .o_Busy     (o_Busy),
        .o_Err_size (o_Err_size),
        .o_Frame_cnt(o_Frame_cnt)
    );

    always #5 i_Sys_clk = ~i_Sys_clk;

    int checks = 0;
    int failures = 0;

    // Output event tallies; scenarios compare deltas across a frame
    int n_cap = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_done = 0, n_dbad = 0, n_donebad = 0;
    logic [DW-1:0] last_data = '0;

    always @(posedge i_Sys_clk) last_data <= i_Data;

    always @(negedge i_Sys_clk) begin
        if (o_Cap_en) begin
            n_cap <= n_cap + 1;
            if (o_Data !== last_data) n_dbad <= n_dbad + 1;
        end
        if (o_Sof) n_sof <= n_sof + 1;
        if (o_Eol) n_eol <= n_eol + 1;
        if (o_Eof) n_eof <= n_eof + 1;
        if (o_Done) begin
            n_done <= n_done + 1;
            if (!o_Eof || o_Busy) n_donebad <= n_donebad + 1;
        end
    end

    // Reference model: sequencer is busy (armed or capturing), with latched count and sticky error
    bit m_busy = 0;
    bit m_stop = 0;
    bit m_err = 0;
    int m_num = 0;
    int m_cnt = 0;

    task automatic tick();
        @(negedge i_Sys_clk);
    endtask

    task automatic pulse_cmd(input bit s, input bit p, input logic [FW-1:0] num);
        i_Start = s;
        i_Stop = p;
        i_Frame_num = num;
        if (p) begin
            m_busy = 0;
            m_stop = 0;
        end else if (s && !m_busy) begin
            m_busy = 1;
            m_num = int'(num);
            m_cnt = 0;
            m_err = 0;
        end
        tick();
        i_Start = 1'b0;
        i_Stop = 1'b0;
    endtask

    task automatic drive_frame(input int nlines, input int bad_line, input bit trunc,
                               input int start_line, input int stop_line,
                               input logic [FW-1:0] cmd_num);
        bit captured, exp_done;
        int w, cap, completed;
        bit bad;
        int s_cap, s_sof, s_eol, s_eof, s_done, s_dbad, s_donebad;
        captured = m_busy;
        cap = 0;
        completed = 0;
        bad = 0;
        s_cap = n_cap; s_sof = n_sof; s_eol = n_eol; s_eof = n_eof;
        s_done = n_done; s_dbad = n_dbad; s_donebad = n_donebad;
        i_Fv = 1'b1;
        i_Lv = 1'b0;
        repeat (1 + $urandom_range(0, 1)) tick();
        for (int i = 0; i < nlines; i++) begin
            w = (i == bad_line) ? W - 1 : W;
            for (int p = 0; p < w; p++) begin
                i_Lv = 1'b1;
                i_Data = DW'($urandom);
                if (p == 0 && i == start_line) begin
                    i_Start = 1'b1;
                    i_Frame_num = cmd_num;
                    if (!m_busy) begin
                        m_busy = 1; m_num = int'(cmd_num); m_cnt = 0; m_err = 0;
                    end
                end
                if (p == 0 && i == stop_line) begin
                    i_Stop = 1'b1;
                    if (captured) m_stop = 1;
                    else m_busy = 0;
                end
                tick();
                i_Start = 1'b0;
                i_Stop = 1'b0;
            end
            cap += w;
            if (trunc && i == nlines - 1) begin
                i_Fv = 1'b0;
                tick();
                i_Lv = 1'b0;
            end else begin
                completed++;
                if (w != W) bad = 1;
                i_Lv = 1'b0;
                if (captured && i == bad_line) begin
                    checks++;
                    if (o_Err_size !== m_err)
                        $display("[TB] FAIL err_before_short_line: got %0b expected %0b", o_Err_size, m_err);
                    tick();
                    checks++;
                    if (o_Err_size !== 1'b1 || o_Eol !== 1'b1)
                        $display("[TB] FAIL err_after_short_line: got err=%0b eol=%0b expected err=1 eol=1",
                                 o_Err_size, o_Eol);
                    if (o_Err_size !== 1'b1 || o_Eol !== 1'b1) failures++;
                end else begin
                    tick();
                end
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        i_Fv = 1'b0;
        repeat (5) tick();

        exp_done = 0;
        if (captured) begin
            m_cnt = (m_cnt + 1) % 256;
            if (bad || completed != H || trunc) m_err = 1;
            exp_done = m_stop || (m_num != 0 && m_cnt == m_num);
            if (exp_done) begin
                m_busy = 0;
                m_stop = 0;
            end
        end

        checks++;
        if ((n_cap - s_cap) !== (captured ? cap : 0)) begin
            failures++;
            $display("[TB] FAIL cap_en_count: got %0d expected %0d", n_cap - s_cap, captured ? cap : 0);
        end
        checks++;
        if ((n_sof - s_sof) !== int'(captured)) begin
            failures++;
            $display("[TB] FAIL sof_count: got %0d expected %0d", n_sof - s_sof, captured);
        end
        checks++;
        if ((n_eol - s_eol) !== (captured ? completed : 0)) begin
            failures++;
            $display("[TB] FAIL eol_count: got %0d expected %0d", n_eol - s_eol, captured ? completed : 0);
        end
        checks++;
        if ((n_eof - s_eof) !== int'(captured)) begin
            failures++;
            $display("[TB] FAIL eof_count: got %0d expected %0d", n_eof - s_eof, captured);
        end
        checks++;
        if ((n_done - s_done) !== int'(exp_done)) begin
            failures++;
            $display("[TB] FAIL done_count: got %0d expected %0d", n_done - s_done, exp_done);
        end
        checks++;
        if ((n_dbad - s_dbad) !== 0 || (n_donebad - s_donebad) !== 0) begin
            failures++;
            $display("[TB] FAIL data_and_done_alignment: got %0d/%0d bad expected 0/0",
                     n_dbad - s_dbad, n_donebad - s_donebad);
        end
        checks++;
        if (o_Frame_cnt !== FW'(m_cnt) || o_Err_size !== m_err || o_Busy !== m_busy) begin
            failures++;
            $display("[TB] FAIL frame_status: got cnt=%0d err=%0b busy=%0b expected cnt=%0d err=%0b busy=%0b",
                     o_Frame_cnt, o_Err_size, o_Busy, m_cnt, m_err, m_busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({o_Data, o_Cap_en, o_Sof, o_Eol, o_Eof, o_Done, o_Busy, o_Err_size, o_Frame_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got busy=%0b cnt=%0d data=%h expected all zero",
                     o_Busy, o_Frame_cnt, o_Data);
        end
        i_Rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (o_Busy !== 1'b0 || o_Frame_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL after_release_idle: got busy=%0b cnt=%0d expected 0/0", o_Busy, o_Frame_cnt);
        end
    endtask

    task automatic test_single_frame();
        pulse_cmd(1, 0, 8'd1);
        checks++;
        if (o_Busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_after_start: got %0b expected 1", o_Busy);
        end
        drive_frame(H, -1, 0, -1, -1, 8'd0);
    endtask

    task automatic test_arm_mid_frame();
        drive_frame(H, -1, 0, 1, -1, 8'd1);
        drive_frame(H, -1, 0, -1, -1, 8'd0);
    endtask

    task automatic test_geometry_error();
        pulse_cmd(1, 0, 8'd2);
        drive_frame(H, 1, 0, -1, -1, 8'd0);
        drive_frame(H - 1, -1, 0, -1, -1, 8'd0);
        pulse_cmd(1, 0, 8'd1);
        checks++;
        if (o_Err_size !== 1'b0 || o_Busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_cleared_by_start: got err=%0b busy=%0b expected 0/1", o_Err_size, o_Busy);
        end
        drive_frame(H, -1, 1, -1, -1, 8'd0);
    endtask

    task automatic test_stop();
        int s_done;
        pulse_cmd(1, 0, 8'd0);
        drive_frame(H, -1, 0, -1, -1, 8'd0);
        drive_frame(H, -1, 0, -1, -1, 8'd0);
        drive_frame(H, -1, 0, -1, 1, 8'd0);
        pulse_cmd(1, 0, 8'd0);
        tick();
        s_done = n_done;
        pulse_cmd(0, 1, 8'd0);
        checks++;
        if (o_Busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stop_while_armed_busy: got %0b expected 0", o_Busy);
        end
        repeat (2) tick();
        checks++;
        if (n_done !== s_done) begin
            failures++;
            $display("[TB] FAIL stop_while_armed_done: got %0d pulses expected 0", n_done - s_done);
        end
    endtask

    task automatic test_ignored_commands();
        pulse_cmd(1, 1, 8'd1);
        tick();
        checks++;
        if (o_Busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_with_stop_busy: got %0b expected 0", o_Busy);
        end
        drive_frame(H, -1, 0, -1, -1, 8'd0);
        pulse_cmd(1, 0, 8'd2);
        drive_frame(H, -1, 0, -1, -1, 8'd0);
        pulse_cmd(1, 0, 8'd5);
        drive_frame(H, -1, 0, -1, -1, 8'd0);
    endtask

    task automatic test_async_reset();
        pulse_cmd(1, 0, 8'd1);
        i_Fv = 1'b1;
        tick();
        i_Lv = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_Cap_en !== 1'b1) begin
            failures++;
            $display("[TB] FAIL capture_before_reset: got %0b expected 1", o_Cap_en);
        end
        i_Rst_n = 1'b0;
        #1;
        checks++;
        if ({o_Data, o_Cap_en, o_Sof, o_Eol, o_Eof, o_Done, o_Busy, o_Err_size, o_Frame_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset_outputs: got cap=%0b busy=%0b data=%h expected all zero",
                     o_Cap_en, o_Busy, o_Data);
        end
        tick();
        i_Lv = 1'b0;
        i_Fv = 1'b0;
        tick();
        i_Rst_n = 1'b1;
        m_busy = 0; m_stop = 0; m_err = 0; m_cnt = 0; m_num = 0;
        repeat (2) tick();
        drive_frame(H, -1, 0, -1, -1, 8'd0);
        pulse_cmd(1, 0, 8'd1);
        drive_frame(H, -1, 0, -1, -1, 8'd0);
    endtask

    task automatic test_random();
        int nl, bl;
        bit tr;
        for (int it = 0; it < 6; it++) begin
            if (m_busy) pulse_cmd(0, 1, 8'd0);
            pulse_cmd(1, 0, FW'($urandom_range(0, 3)));
            for (int f = 0; f < 4 && m_busy; f++) begin
                nl = H - 1 + $urandom_range(0, 2);
                bl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
                tr = ($urandom_range(0, 5) == 0);
                drive_frame(nl, bl, tr, -1, ($urandom_range(0, 7) == 0) ? 1 : -1, 8'd0);
            end
        end
        if (m_busy) pulse_cmd(0, 1, 8'd0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_arm_mid_frame();
        test_geometry_error();
        test_stop();
        test_ignored_commands();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
